// File: rtl/axi_lite_order_slave_if.sv
// AXI4-Lite channel bundle between host interconnect and the order slave.
// Pure wiring, no latency; flow control is plain valid/ready per channel.
// Backpressure: each channel stalls independently while its ready is low.
interface axi_lite_order_slave_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_order_slave.sv
// AXI-Lite control slave: cfg registers, order push window (0x48) into a FWFT FIFO, free-slot status (0x4C).
// Latency: bvalid one cycle after the later AW/W handshake; rvalid one cycle after AR handshake.
// Backpressure: no new AW/W while a response waits on bready; no new AR until rready; full FIFO push -> SLVERR.
module axi_lite_order_slave #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int NUM_CFG         = 18,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_areset,
    axi_lite_order_slave_if.slave    s00_axi,
    output logic [NUM_CFG*32-1:0]    cfg_regs,
    output logic [31:0]              order_data,
    output logic                     order_valid,
    input  logic                     order_ready
);
    localparam int DW   = AXIL_DATA_WIDTH;
    localparam int IDXW = AXIL_ADDR_WIDTH - 2;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    // Word indices of 0x48 and 0x4C
    localparam logic [IDXW-1:0] PUSH_IDX = IDXW'(18);
    localparam logic [IDXW-1:0] STAT_IDX = IDXW'(19);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [AXIL_ADDR_WIDTH-1:0] awaddr_q;
    logic [DW-1:0]              wdata_q;
    logic [DW/8-1:0]            wstrb_q;
    logic [1:0]                 bresp_q, bresp_d;
    logic [DW-1:0]              rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [DW-1:0]              cfg_q [NUM_CFG];
    logic [DW-1:0]              fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]            count_q, count_d;

    logic aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
    logic commit, fifo_full, push_en, pop_en;
    logic [AXIL_ADDR_WIDTH-1:0] c_addr;
    logic [DW-1:0]              c_data;
    logic [DW/8-1:0]            c_strb;
    logic [IDXW-1:0]            c_idx, r_idx;
    logic                       unused_bits;

    assign aw_rdy = !s00_axi_areset && (wstate_q == W_IDLE || wstate_q == W_HAVE_W);
    assign w_rdy  = !s00_axi_areset && (wstate_q == W_IDLE || wstate_q == W_HAVE_AW);
    assign ar_rdy = !s00_axi_areset && (rstate_q == R_IDLE);
    assign aw_hs  = s00_axi.awvalid && aw_rdy;
    assign w_hs   = s00_axi.wvalid && w_rdy;
    assign ar_hs  = s00_axi.arvalid && ar_rdy;

    assign s00_axi.awready = aw_rdy;
    assign s00_axi.wready  = w_rdy;
    assign s00_axi.arready = ar_rdy;
    assign s00_axi.bvalid  = (wstate_q == W_RESP);
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.rvalid  = (rstate_q == R_RESP);
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, c_addr[1:0], s00_axi.araddr[1:0]};

    // The commit uses whichever half arrives live this cycle and the latched copy of the other
    always_comb begin
        wstate_d = wstate_q;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit   = 1'b1;
                    c_addr   = s00_axi.awaddr;
                    c_data   = s00_axi.wdata;
                    c_strb   = s00_axi.wstrb;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit   = 1'b1;
                    c_data   = s00_axi.wdata;
                    c_strb   = s00_axi.wstrb;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit   = 1'b1;
                    c_addr   = s00_axi.awaddr;
                    wstate_d = W_RESP;
                end
            end
            W_RESP:  if (s00_axi.bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    assign c_idx     = c_addr[AXIL_ADDR_WIDTH-1:2];
    assign r_idx     = s00_axi.araddr[AXIL_ADDR_WIDTH-1:2];
    assign fifo_full = (count_q == CNTW'(FIFO_DEPTH));
    assign push_en   = commit && (c_idx == PUSH_IDX) && !fifo_full;
    assign pop_en    = order_valid && order_ready;
    assign count_d   = count_q + CNTW'(push_en) - CNTW'(pop_en);

    always_comb begin
        bresp_d = RESP_SLVERR;
        if (c_idx < IDXW'(NUM_CFG) || (c_idx == PUSH_IDX && !fifo_full)) begin
            bresp_d = RESP_OKAY;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = '0;
        rresp_d  = RESP_SLVERR;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (r_idx == IDXW'(i)) begin
                rdata_d = cfg_q[i];
                rresp_d = RESP_OKAY;
            end
        end
        if (r_idx == PUSH_IDX) begin
            rresp_d = RESP_OKAY;
        end
        if (r_idx == STAT_IDX) begin
            rdata_d = DW'(FIFO_DEPTH) - DW'(count_q);
            rresp_d = RESP_OKAY;
        end
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (s00_axi.rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            count_q  <= count_d;
            if (aw_hs) awaddr_q <= s00_axi.awaddr;
            if (w_hs) begin
                wdata_q <= s00_axi.wdata;
                wstrb_q <= s00_axi.wstrb;
            end
            if (commit) bresp_q <= bresp_d;
            if (ar_hs) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (commit && c_idx == IDXW'(i)) begin
                    for (int b = 0; b < DW/8; b++) begin
                        if (c_strb[b]) cfg_q[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (push_en) fifo_mem[wr_ptr_q] <= c_data;
    end

    assign order_data  = fifo_mem[rd_ptr_q];
    assign order_valid = (count_q != '0);

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_flat
        assign cfg_regs[32*g +: 32] = cfg_q[g];
    end
endmodule

// File: tb/tb_axi_lite_order_slave.sv
// Directed bench for axi_lite_order_slave: transaction-level model (cfg array + order queue) checked every cycle,
// plus literal expectations on register reads, responses and drain order.
module tb_axi_lite_order_slave;
    localparam int DEPTH = 8;
    localparam int NCFG  = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_order_slave_if #(.AW(8), .DW(32)) bus ();
    logic [NCFG*32-1:0] cfg_regs;
    logic [31:0]        order_data;
    logic               order_valid;
    logic               order_ready;

    axi_lite_order_slave #(
        .AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(8), .NUM_CFG(NCFG), .FIFO_DEPTH(DEPTH)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (bus),
        .cfg_regs       (cfg_regs),
        .order_data     (order_data),
        .order_valid    (order_valid),
        .order_ready    (order_ready)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_cfg [NCFG];
    logic [31:0] m_q [$];
    bit          m_aw_have, m_w_have, m_b_pend, m_r_pend;
    logic [7:0]  m_awaddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    bit          model_on = 0;
    logic [31:0] got [$];

    always @(posedge clk) begin : model_p
        bit aw_hs, w_hs, ar_hs, pop, full, commit;
        logic [7:0]  ca;
        logic [31:0] cd;
        logic [3:0]  cs;
        int idx;
        if (rst) begin
            for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
            m_q.delete();
            m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
            model_on = 1;
        end else begin
            aw_hs = bus.awvalid && !m_aw_have && !m_b_pend;
            w_hs  = bus.wvalid && !m_w_have && !m_b_pend;
            ar_hs = bus.arvalid && !m_r_pend;
            full  = (m_q.size() == DEPTH);
            pop   = (m_q.size() != 0) && order_ready;
            if (m_r_pend) begin
                if (bus.rready) m_r_pend = 0;
            end else if (ar_hs) begin
                idx = int'(bus.araddr[7:2]);
                m_r_pend = 1;
                if (idx < NCFG) begin m_rdata = m_cfg[idx]; m_rresp = 2'b00; end
                else if (idx == 18) begin m_rdata = 0; m_rresp = 2'b00; end
                else if (idx == 19) begin m_rdata = DEPTH - m_q.size(); m_rresp = 2'b00; end
                else begin m_rdata = 0; m_rresp = 2'b10; end
            end
            ca = m_aw_have ? m_awaddr : bus.awaddr;
            cd = m_w_have ? m_wdata : bus.wdata;
            cs = m_w_have ? m_wstrb : bus.wstrb;
            commit = (aw_hs || m_aw_have) && (w_hs || m_w_have) && !m_b_pend;
            if (m_b_pend && bus.bready) m_b_pend = 0;
            if (pop) void'(m_q.pop_front());
            if (commit) begin
                idx = int'(ca[7:2]);
                if (idx < NCFG) begin
                    for (int b = 0; b < 4; b++) if (cs[b]) m_cfg[idx][8*b +: 8] = cd[8*b +: 8];
                    m_bresp = 2'b00;
                end else if (idx == 18) begin
                    if (full) m_bresp = 2'b10;
                    else begin m_q.push_back(cd); m_bresp = 2'b00; end
                end else begin
                    m_bresp = 2'b10;
                end
                m_b_pend = 1; m_aw_have = 0; m_w_have = 0;
            end else begin
                if (aw_hs) begin m_aw_have = 1; m_awaddr = bus.awaddr; end
                if (w_hs)  begin m_w_have = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("awready", bus.awready, !rst && !m_aw_have && !m_b_pend);
            chk("wready",  bus.wready,  !rst && !m_w_have && !m_b_pend);
            chk("arready", bus.arready, !rst && !m_r_pend);
            chk("bvalid",  bus.bvalid,  m_b_pend);
            if (m_b_pend) chk("bresp", bus.bresp, m_bresp);
            chk("rvalid",  bus.rvalid,  m_r_pend);
            if (m_r_pend) begin
                chk("rdata", bus.rdata, m_rdata);
                chk("rresp", bus.rresp, m_rresp);
            end
            chk("order_valid", order_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("order_data", order_data, m_q[0]);
            for (int i = 0; i < NCFG; i++) chk("cfg_reg", cfg_regs[32*i +: 32], m_cfg[i]);
            if (!rst && order_valid && order_ready) got.push_back(order_data);
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) order_ready = 1'($urandom_range(0, 1));
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int w_lead, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, af, wf;
        int cyc = 0;
        @(posedge clk); #1;
        bus.wvalid = 1; bus.wdata = d; bus.wstrb = s;
        if (w_lead == 0) begin bus.awvalid = 1; bus.awaddr = a; end
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            af = bus.awvalid && bus.awready;
            wf = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (af) begin bus.awvalid = 0; aw_done = 1; end
            if (wf) begin bus.wvalid = 0; w_done = 1; end
            cyc++;
            if (cyc == w_lead && !aw_done) begin bus.awvalid = 1; bus.awaddr = a; end
        end
        if (!(aw_done && w_done)) begin
            chk("wr_handshake_timeout", 0, 1);
            bus.awvalid = 0; bus.wvalid = 0; resp = 2'bxx;
            return;
        end
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (bus.bvalid) break;
            cyc++;
        end
        if (cyc == 100) begin chk("wr_bvalid_timeout", 0, 1); resp = 2'bxx; end
        else resp = bus.bresp;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit f = 0;
        int cyc = 0;
        @(posedge clk); #1;
        bus.arvalid = 1; bus.araddr = a;
        while (!f && cyc < 100) begin
            @(negedge clk); f = bus.arready;
            @(posedge clk); #1; cyc++;
        end
        bus.arvalid = 0;
        if (!f) begin chk("rd_ar_timeout", 0, 1); d = 'x; resp = 'x; return; end
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (bus.rvalid) break;
            cyc++;
        end
        if (cyc == 100) begin chk("rd_rvalid_timeout", 0, 1); d = 'x; resp = 'x; end
        else begin d = bus.rdata; resp = bus.rresp; end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
        bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 1;
        order_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_readies", {29'b0, bus.awready, bus.wready, bus.arready}, 0);
        chk("reset_valids", {29'b0, bus.bvalid, bus.rvalid, order_valid}, 0);
        chk("reset_resp", {28'b0, bus.bresp, bus.rresp}, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_cfg", {31'b0, |cfg_regs}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("ready_after_reset", {29'b0, bus.awready, bus.wready, bus.arready}, 3'b111);

        rd(8'h4C, d, r); chk("status_idle", d, 8); chk("status_idle_resp", r, 0);
        rd(8'h00, d, r); chk("cfg0_idle", d, 0);

        wr(8'h04, 32'hA5A5A5A5, 4'b0101, 0, r); chk("cfg4_wr_resp", r, 0);
        rd(8'h04, d, r); chk("cfg4_rd", d, 32'h00A500A5);
        wr(8'h08, 32'hA5A5A5A5, 4'b0101, 3, r); chk("cfg8_wfirst_resp", r, 0);
        rd(8'h08, d, r); chk("cfg8_rd", d, 32'h00A500A5);

        for (int i = 1; i <= 8; i++) begin
            wr(8'h48, i, 4'hF, 0, r); chk("push_resp", r, 0);
        end
        rd(8'h4C, d, r); chk("status_full", d, 0);
        wr(8'h48, 32'hDEAD, 4'hF, 0, r); chk("push_full_resp", r, 2'b10);
        rd(8'h4C, d, r); chk("status_still_full", d, 0);

        got.delete();
        order_ready = 1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_order", got[i], i + 1);
        chk("drain_empty", order_valid, 0);
        rd(8'h4C, d, r); chk("status_drained", d, 8);

        wr(8'h4C, 32'h5, 4'hF, 0, r); chk("wr_status_resp", r, 2'b10);
        rd(8'h4C, d, r); chk("status_after_wr", d, 8);
        rd(8'h50, d, r); chk("rd_50_data", d, 0); chk("rd_50_resp", r, 2'b10);
        rd(8'h48, d, r); chk("rd_48_data", d, 0); chk("rd_48_resp", r, 0);

        bus.bready = 0;
        wr(8'h0C, 32'h12345678, 4'hF, 0, r); chk("bp_resp", r, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_bvalid", bus.bvalid, 1);
            chk("bp_bresp", bus.bresp, 0);
            chk("bp_awready", bus.awready, 0);
        end
        @(posedge clk); #1 bus.bready = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("bp_released", bus.bvalid, 0);

        got.delete();
        rnd_ready = 1;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            d = 0;
            while (d == 0 && n < 200) begin
                rd(8'h4C, d, r);
                n++;
            end
            if (d == 0) chk("poll_timeout", 0, 1);
            wr(8'h48, 32'h100 + k, 4'hF, 0, r); chk("poll_push_resp", r, 0);
        end
        @(posedge clk); #1;
        rnd_ready = 0; order_ready = 1;
        n = 0;
        while (got.size() < 20 && n < 200) begin @(posedge clk); n++; end
        @(negedge clk);
        chk("poll_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("poll_order", got[i], 32'h100 + i);

        @(posedge clk); #1 order_ready = 0;
        wr(8'h48, 32'hAA, 4'hF, 0, r);
        wr(8'h48, 32'hBB, 4'hF, 0, r);
        @(posedge clk); #1;
        bus.awvalid = 1; bus.awaddr = 8'h10;
        begin
            bit f = 0;
            n = 0;
            while (!f && n < 50) begin
                @(negedge clk); f = bus.awready;
                @(posedge clk); #1; n++;
            end
            if (!f) chk("mid_aw_timeout", 0, 1);
        end
        bus.awvalid = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1 rst = 0;
        repeat (4) begin
            @(negedge clk); chk("mid_no_bvalid", bus.bvalid, 0);
        end
        chk("mid_fifo_empty", order_valid, 0);
        chk("mid_cfg_zero", {31'b0, |cfg_regs}, 0);
        wr(8'h10, 32'hCAFEF00D, 4'hF, 0, r); chk("post_reset_wr_resp", r, 0);
        rd(8'h10, d, r); chk("post_reset_rd", d, 32'hCAFEF00D);
        rd(8'h4C, d, r); chk("post_reset_status", d, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_order_slave.md
# axi_lite_order_slave

AXI4-Lite slave at the accelerator's control port. It terminates the host's instruction stream: a bank of read/write configuration registers, a push-only order window at 0x48 that feeds an order FIFO toward the accelerator core, and a read-only free-slot status register at 0x4C. Software polls 0x4C until it reads nonzero, then writes 0x48. The block sits between the host AXI-Lite interconnect and the core's order decoder.

## Interface
- AXIL_DATA_WIDTH, 32, data width; only 32 is supported.
- AXIL_ADDR_WIDTH, 8, byte address width.
- NUM_CFG, 18, number of configuration registers at 0x00..(NUM_CFG-1)*4; NUM_CFG*4 must be <= 0x48.
- FIFO_DEPTH, 8, order FIFO depth; power of two, 2..128.
- s00_axi_aclk, in, 1, single clock for everything.
- s00_axi_areset, in, 1, synchronous, active-high reset.
- s00_axi_awaddr/awprot/awvalid/awready, AXI-Lite AW channel; widths AXIL_ADDR_WIDTH/3/1/1. awprot is ignored.
- s00_axi_wdata/wstrb/wvalid/wready, AXI-Lite W channel; widths 32/4/1/1.
- s00_axi_bresp/bvalid/bready, AXI-Lite B channel; widths 2/1/1.
- s00_axi_araddr/arprot/arvalid/arready, AXI-Lite AR channel; arprot is ignored.
- s00_axi_rdata/rresp/rvalid/rready, AXI-Lite R channel; widths 32/2/1/1.
- cfg_regs, out, NUM_CFG*32, flattened configuration registers; register i is at bits [32i+31:32i].
- order_data, out, 32, FIFO head word.
- order_valid, out, 1, FIFO not empty.
- order_ready, in, 1, core consumes the head when valid && ready.

## Operation
- Address decode uses addr[AXIL_ADDR_WIDTH-1:2]; addr[1:0] are ignored.
- Register map:
  - 0x00..: cfg regs, R/W, byte-wise per wstrb.
  - 0x48: order push. Write-only; wstrb is ignored and the full word is pushed. Reads return 0 with OKAY.
  - 0x4C: status, read-only, value = FIFO_DEPTH - count (nonzero iff not full). A write returns SLVERR (2'b10) and has no effect.
  - Any other address: read returns 0 with SLVERR; write returns SLVERR with no effect.
- A push to 0x48 while the FIFO is full drops the data and returns SLVERR. Otherwise the push responds OKAY.
- Write channel FSM:
  - States: IDLE, HAVE_AW, HAVE_W, RESP.
  - awready = 1 in IDLE and HAVE_W. wready = 1 in IDLE and HAVE_AW.
  - AW and W may arrive in either order or in the same cycle; each is latched at its handshake.
  - The write commits at the edge where the later of the two handshakes completes. The FSM then enters RESP with bvalid = 1.
  - RESP holds bvalid and bresp until bready, then returns to IDLE. No new AW/W is accepted in RESP.
- Read channel FSM:
  - States: R_IDLE, R_RESP.
  - arready = 1 only in R_IDLE.
  - On AR handshake, rdata/rresp are registered from the state at that edge, and the FSM enters R_RESP with rvalid = 1.
  - R_RESP holds rdata/rresp stable until rready.
- Read and write channels are independent; both may be active in the same cycle.
- FIFO:
  - First-word fall-through: order_data is valid whenever order_valid = 1.
  - A push and a pop in the same cycle leave count unchanged and are legal even when full or empty-plus-push, as follows:
    - When full, the push is still rejected, because fullness is evaluated before the pop.
    - When empty, the pop does nothing because order_valid = 0.
  - Read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (s00_axi_areset = 1 at an edge):
  - awready, wready, arready, bvalid, rvalid, order_valid = 0.
  - bresp, rresp, rdata = 0. cfg_regs = 0. FIFO empty, count = 0.
  - Both FSMs go to idle. Any in-flight transaction is abandoned and produces no response.
- Ready signals go high in the first cycle after reset deasserts.
- Write latency: last of AW/W handshakes in cycle N → bvalid high in N+1.
  - A cfg register update is visible on cfg_regs in N+1.
  - A pushed order is visible on order_valid/order_data in N+1.
- Read latency: AR handshake in cycle N → rvalid and data in N+1. Best throughput is one read per 2 cycles when rready is held high.
- Status read coinciding with a push or pop commit at the same edge returns the pre-edge count.
- Status read coinciding with a pop at the same edge: the pop takes effect at that edge and the value is the pre-edge count.
- Steady-state write throughput is one write per 2 cycles (handshake, then response) with bready held high.

## Test plan
- Reset then idle:
  - All outputs at their reset values during reset.
  - Read 0x4C returns FIFO_DEPTH (8) with OKAY.
  - Read 0x00 returns 0.
- Cfg write 0x04 = 0xA5A5A5A5 with wstrb = 4'b0101 → read 0x04 returns 0x00A500A5.
  - cfg_regs[63:32] changes in the cycle bvalid rises.
  - Repeat with W presented 3 cycles before AW; same result.
- Push 8 orders 0x1..0x8 to 0x48 with order_ready = 0:
  - 0x4C reads 0.
  - A 9th push 0xDEAD returns SLVERR and is not stored.
  - Then raise order_ready: 0x1..0x8 drain in order, one per cycle; order_valid falls after the 8th; 0x4C reads 8.
- Host-style poll loop: poll 0x4C until nonzero, then write 0x48, repeated for 20 orders with order_ready toggling pseudo-randomly.
  - No SLVERR responses.
  - All 20 orders arrive in order with no loss or duplicates.
- Errors:
  - Write 0x4C returns SLVERR; status is unchanged.
  - Read 0x50 returns 0 with SLVERR.
  - Read 0x48 returns 0 with OKAY.
  - Backpressure: bready held low 5 cycles → bvalid/bresp stable throughout and awready = 0.
- Reset mid-operation:
  - Assert reset in the cycle after AW handshake, before W → no bvalid afterwards.
  - FIFO empty, cfg_regs = 0.
  - A subsequent full write completes normally.
